// File: rtl/writeback_queue.sv
// Write-back queue: a circular FIFO of register-file writes retired one per cycle
// through an output register, with three combinational youngest-first forwarding lookups.
module writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     InValid,
  input  logic [ADDR_W-1:0]        InReg,
  input  logic [DATA_W-1:0]        InData,
  output logic                     InReady,
  input  logic                     Hold,
  input  logic                     Flush,
  output logic [ADDR_W-1:0]        WriteReg,
  output logic [DATA_W-1:0]        Data,
  output logic                     WriteEnable,
  input  logic [ADDR_W-1:0]        Look1,
  input  logic [ADDR_W-1:0]        Look2,
  input  logic [ADDR_W-1:0]        Look3,
  output logic                     Hit1,
  output logic                     Hit2,
  output logic                     Hit3,
  output logic [DATA_W-1:0]        Fwd1,
  output logic [DATA_W-1:0]        Fwd2,
  output logic [DATA_W-1:0]        Fwd3,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic [ADDR_W-1:0]  r_wr_reg;
  logic [DATA_W-1:0]  r_wr_data;
  logic               r_we;

  logic w_push;
  logic w_pop;
  logic [2:0][ADDR_W-1:0] w_look;

  assign InReady = (r_count != CNT_W'(DEPTH));
  // Writes to register 0 complete the handshake but are never stored.
  assign w_push  = InValid && InReady && !Flush && (InReg != '0);
  assign w_pop   = !Hold && !Flush && (r_count != '0);

  // NOTE: storage is not reset; r_count alone decides which entries are live,
  // so stale contents are never observable and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= '{addr: InReg, data: InData};
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_wr_reg  <= '0;
      r_wr_data <= '0;
      r_we      <= 1'b0;
    end else if (Flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop) begin
        r_head    <= r_head + PTR_W'(1);
        r_wr_reg  <= r_mem[r_head].addr;
        r_wr_data <= r_mem[r_head].data;
        r_we      <= 1'b1;
      end else begin
        r_we <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_look = {Look3, Look2, Look1};

  for (genvar g = 0; g < 3; g++) begin : g_lookup
    logic              w_hit;
    logic [DATA_W-1:0] w_fwd;

    // Scan oldest to youngest so the youngest matching write wins.
    // NOTE: defaults first keep this block free of inferred latches.
    always_comb begin
      w_hit = 1'b0;
      w_fwd = '0;
      if (w_look[g] != '0) begin
        if (r_we && (r_wr_reg == w_look[g])) begin
          w_hit = 1'b1;
          w_fwd = r_wr_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if ((CNT_W'(i) < r_count) &&
              (r_mem[r_head + PTR_W'(i)].addr == w_look[g])) begin
            w_hit = 1'b1;
            w_fwd = r_mem[r_head + PTR_W'(i)].data;
          end
        end
      end
    end
  end

  assign Hit1        = g_lookup[0].w_hit;
  assign Hit2        = g_lookup[1].w_hit;
  assign Hit3        = g_lookup[2].w_hit;
  assign Fwd1        = g_lookup[0].w_fwd;
  assign Fwd2        = g_lookup[1].w_fwd;
  assign Fwd3        = g_lookup[2].w_fwd;
  assign WriteReg    = r_wr_reg;
  assign Data        = r_wr_data;
  assign WriteEnable = r_we;
  assign Count       = r_count;

endmodule
